// File: rtl/sign_alu_pkg.sv
// ---------------------------------------------------------------------------
// sign_alu_pkg
// Shared definitions for the signed ALU datapath:
//   OP_ADD / OP_SUB  - operation encoding on the op input
//   state_t          - serial add/subtract FSM states (IDLE, RUN, DONE)
//   sat_limit()      - signed max (neg = 0) or signed min (neg = 1) for a width
// ---------------------------------------------------------------------------
package sign_alu_pkg;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    // Widest operand sat_limit() can describe.
    localparam int unsigned SAT_MAX_W = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Signed extreme for a given width, zero-extended to SAT_MAX_W bits.
    // Callers keep the low 'width' bits:
    //   neg = 0 -> 2^(width-1) - 1
    //   neg = 1 -> -2^(width-1)
    function automatic logic [SAT_MAX_W-1:0] sat_limit(input int unsigned width,
                                                       input logic        neg);
        logic [SAT_MAX_W-1:0] msb;
        msb = SAT_MAX_W'(1) << (width - 1);
        return neg ? msb : (msb - SAT_MAX_W'(1));
    endfunction

endpackage

// File: rtl/chunk_adder.sv
// ---------------------------------------------------------------------------
// chunk_adder
// W-bit combinational ripple adder built from full_adder cells.
//   a_i, b_i - W-bit addends
//   c_i      - carry into bit 0
//   sum_o    - W-bit sum
//   c_o      - carry out of bit W-1
//   c_top_o  - carry into bit W-1; XOR with c_o gives signed overflow
// ---------------------------------------------------------------------------
module chunk_adder #(
    parameter int W = 8
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic         c_i,
    output logic [W-1:0] sum_o,
    output logic         c_o,
    output logic         c_top_o
);

    logic [W:0] c;

    assign c[0] = c_i;

    for (genvar i = 0; i < W; i++) begin : g_bit
        full_adder u_fa (
            .a_i (a_i[i]),
            .b_i (b_i[i]),
            .c_i (c[i]),
            .s_o (sum_o[i]),
            .c_o (c[i+1])
        );
    end

    assign c_o     = c[W];
    assign c_top_o = c[W-1];

endmodule

// File: rtl/full_adder.sv
// ---------------------------------------------------------------------------
// full_adder
// One-bit full adder cell.
//   a_i, b_i - addend bits
//   c_i      - carry in
//   s_o      - sum bit
//   c_o      - carry out
// ---------------------------------------------------------------------------
module full_adder (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic s_o,
    output logic c_o
);

    assign s_o = a_i ^ b_i ^ c_i;
    assign c_o = (a_i & b_i) | (c_i & (a_i ^ b_i));

endmodule

// File: rtl/sign_addsub_serial.sv
// ---------------------------------------------------------------------------
// sign_addsub_serial
// Multi-cycle signed add/subtract. A WIDTH-bit operand pair is processed
// CHUNK bits per clock (N = WIDTH/CHUNK RUN cycles). Latency from accept to
// out_valid is N+1 cycles.
//
// Parameters:
//   WIDTH - operand/result width, >= 2, multiple of CHUNK (max 64 with SAT)
//   CHUNK - bits processed per cycle
//
// Ports:
//   clk, rst_n          - clock, synchronous active-low reset
//   in_valid, in_ready  - operand handshake (in_ready high only in IDLE)
//   op                  - 0 = add (a+b+cin), 1 = subtract (a-b-cin)
//   a, b, cin           - signed operands, carry/borrow in
//   out_valid, out_ready- result handshake (out_valid high only in DONE)
//   out                 - signed result
//   of, cf, zf, nf      - overflow, carry/borrow out, zero, negative
//   dbg_state           - current FSM state
//
// Handshake: a transfer happens on a rising clk edge where valid && ready
// are both high. While valid is high, the presenting side holds its data
// stable until the transfer. in_valid outside IDLE is ignored.
//
// Build option: define SIGN_ADDSUB_SAT_EN to clamp overflowing results to
// the signed extreme. Without it, out is the wrapped two's-complement sum.
// ---------------------------------------------------------------------------
module sign_addsub_serial
    import sign_alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             of,
    output logic             cf,
    output logic             zf,
    output logic             nf,
    output state_t           dbg_state
);

    localparam int N     = WIDTH / CHUNK;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N - 1);

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;
    logic               carry_q, carry_d;
    logic [WIDTH-1:0]   a_q,     a_d;
    logic [WIDTH-1:0]   b_q,     b_d;
    logic               op_q,    op_d;
    logic [WIDTH-1:0]   res_q,   res_d;
    logic               of_q,    of_d;
    logic               cf_q,    cf_d;
    logic               zf_q,    zf_d;
    logic               nf_q,    nf_d;

    // -----------------------------------------------------------------------
    // Chunk datapath
    // -----------------------------------------------------------------------
    logic [CHUNK-1:0] a_slice;
    logic [CHUNK-1:0] b_slice;
    logic [CHUNK-1:0] b_eff;
    logic [CHUNK-1:0] sum_slice;
    logic             chunk_cout;
    logic             chunk_ctop;
    logic [WIDTH-1:0] res_merged;
    logic [WIDTH-1:0] res_final;
    logic             of_final;

    // Slice selection by comparing the counter against each constant
    // position keeps every part-select static.
    always_comb begin
        a_slice = '0;
        b_slice = '0;
        for (int k = 0; k < N; k++) begin
            if (cnt_q == CNT_W'(k)) begin
                a_slice = a_q[k*CHUNK +: CHUNK];
                b_slice = b_q[k*CHUNK +: CHUNK];
            end
        end
    end

    // Subtraction is a + ~b + ~borrow; the inverted borrow is folded into
    // the carry register at accept time.
    assign b_eff = (op_q == OP_SUB) ? ~b_slice : b_slice;

    chunk_adder #(
        .W (CHUNK)
    ) u_chunk (
        .a_i     (a_slice),
        .b_i     (b_eff),
        .c_i     (carry_q),
        .sum_o   (sum_slice),
        .c_o     (chunk_cout),
        .c_top_o (chunk_ctop)
    );

    // Result register with the current chunk's sum dropped into place.
    always_comb begin
        res_merged = res_q;
        for (int k = 0; k < N; k++) begin
            if (cnt_q == CNT_W'(k)) begin
                res_merged[k*CHUNK +: CHUNK] = sum_slice;
            end
        end
    end

    // Only meaningful on the last chunk, where the top slice bit is the
    // sign bit of the whole word.
    assign of_final = chunk_ctop ^ chunk_cout;

`ifdef SIGN_ADDSUB_SAT_EN
    // On overflow the true result's sign equals a's sign (both effective
    // operands share it), so a[MSB] picks the extreme to clamp to.
    logic [SAT_MAX_W-1:0] sat_val;

    always_comb begin
        sat_val   = sat_limit(WIDTH, a_q[WIDTH-1]);
        res_final = of_final ? sat_val[WIDTH-1:0] : res_merged;
    end
`else
    assign res_final = res_merged;
`endif

    // -----------------------------------------------------------------------
    // FSM: next state and datapath register updates
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        res_d   = res_q;
        of_d    = of_q;
        cf_d    = cf_q;
        zf_d    = zf_q;
        nf_d    = nf_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    op_d    = op;
                    carry_d = (op == OP_SUB) ? ~cin : cin;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end

            RUN: begin
                res_d   = res_merged;
                carry_d = chunk_cout;
                if (cnt_q == LAST_CNT) begin
                    res_d   = res_final;
                    of_d    = of_final;
                    // Carry-out of a + ~b is the inverse of the borrow.
                    cf_d    = (op_q == OP_SUB) ? ~chunk_cout : chunk_cout;
                    zf_d    = (res_final == '0);
                    nf_d    = res_final[WIDTH-1];
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= 1'b0;
            res_q   <= '0;
            of_q    <= 1'b0;
            cf_q    <= 1'b0;
            zf_q    <= 1'b0;
            nf_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            res_q   <= res_d;
            of_q    <= of_d;
            cf_q    <= cf_d;
            zf_q    <= zf_d;
            nf_q    <= nf_d;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign out       = res_q;
    assign of        = of_q;
    assign cf        = cf_q;
    assign zf        = zf_q;
    assign nf        = nf_q;
    assign dbg_state = state_q;

endmodule
